// File: rtl/serial_frame_receiver_pkg.sv
// rtl/serial_frame_receiver_pkg.sv - shared frame geometry and receiver state type
package serial_frame_receiver_pkg;

    localparam int BYTE_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_e;

endpackage

// File: rtl/serial_frame_receiver_if.sv
// rtl/serial_frame_receiver_if.sv - serial input stream and per-byte report bundle
interface serial_frame_receiver_if #(
    parameter int BYTE_W = serial_frame_receiver_pkg::BYTE_W,
    parameter int ADDR_W = serial_frame_receiver_pkg::ADDR_W
);

    logic              din;
    logic              din_valid;
    logic              frame_start;
    logic [BYTE_W-1:0] byte_out;
    logic              byte_valid;
    logic [ADDR_W-1:0] byte_addr;
    logic              frame_done;

    modport master (
        output din, din_valid, frame_start,
        input  byte_out, byte_valid, byte_addr, frame_done
    );

    modport slave (
        input  din, din_valid, frame_start,
        output byte_out, byte_valid, byte_addr, frame_done
    );

endinterface

// File: rtl/serial_frame_receiver_capture_ram.sv
// rtl/serial_frame_receiver_capture_ram.sv - DEPTH x BYTE_W capture array, one write port, registered read
module capture_ram #(
    parameter int BYTE_W = serial_frame_receiver_pkg::BYTE_W,
    parameter int DEPTH  = serial_frame_receiver_pkg::DEPTH,
    parameter int ADDR_W = serial_frame_receiver_pkg::ADDR_W
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [BYTE_W-1:0] rd_data
);

    // Contents are deliberately not reset so a captured frame survives a reset.
    logic [BYTE_W-1:0] mem [DEPTH];
    logic [BYTE_W-1:0] rd_data_d;
    logic [BYTE_W-1:0] rd_data_q;

    always_comb begin
        rd_data_d = mem[rd_addr];
    end

    always_ff @(posedge sysclk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/serial_frame_receiver.sv
// rtl/serial_frame_receiver.sv - MSB-first serial deframer capturing one frame of bytes into a local buffer
module serial_frame_receiver #(
    parameter int BYTE_W = serial_frame_receiver_pkg::BYTE_W,
    parameter int DEPTH  = serial_frame_receiver_pkg::DEPTH,
    parameter int ADDR_W = serial_frame_receiver_pkg::ADDR_W
) (
    input  logic                          sysclk,
    input  logic                          rst_n,
    serial_frame_receiver_if.slave        bus,
    output logic                          busy,
    output logic                          sync_err,
    input  logic                          clear_err,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic [BYTE_W-1:0]             rd_data
);

    import serial_frame_receiver_pkg::*;

    localparam int                BC_W      = $clog2(BYTE_W);
    localparam logic [BC_W-1:0]   LAST_BIT  = BC_W'(BYTE_W - 1);
    localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(DEPTH - 1);

    rx_state_e         state_q,      state_d;
    logic [BYTE_W-2:0] shreg_q,      shreg_d;
    logic [BC_W-1:0]   bit_cnt_q,    bit_cnt_d;
    logic [ADDR_W-1:0] byte_cnt_q,   byte_cnt_d;
    logic [BYTE_W-1:0] byte_out_q,   byte_out_d;
    logic [ADDR_W-1:0] byte_addr_q,  byte_addr_d;
    logic              byte_valid_q, byte_valid_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q,       busy_d;
    logic              sync_err_q,   sync_err_d;

    logic              wr_en;
    logic [BYTE_W-1:0] wr_data;
    logic              err_set;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        byte_out_d   = byte_out_q;
        byte_addr_d  = byte_addr_q;
        byte_valid_d = 1'b0;
        frame_done_d = 1'b0;
        busy_d       = busy_q;
        wr_en        = 1'b0;
        wr_data      = {shreg_q, bus.din};
        err_set      = 1'b0;

        if (bus.din_valid) begin
            // A start bit always resynchronises, even on what would have completed a byte.
            if (bus.frame_start) begin
                shreg_d    = {{(BYTE_W-2){1'b0}}, bus.din};
                bit_cnt_d  = BC_W'(1);
                byte_cnt_d = '0;
                state_d    = SHIFT;
                busy_d     = 1'b1;
                err_set    = (state_q == SHIFT);
            end else if (state_q == SHIFT) begin
                shreg_d = wr_data[BYTE_W-2:0];
                if (bit_cnt_q == LAST_BIT) begin
                    wr_en        = 1'b1;
                    byte_out_d   = wr_data;
                    byte_addr_d  = byte_cnt_q;
                    byte_valid_d = 1'b1;
                    bit_cnt_d    = '0;
                    byte_cnt_d   = byte_cnt_q + ADDR_W'(1);
                    if (byte_cnt_q == LAST_BYTE) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                        busy_d       = 1'b0;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BC_W'(1);
                end
            end
        end

        sync_err_d = err_set ? 1'b1 : (clear_err ? 1'b0 : sync_err_q);
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            byte_out_q   <= '0;
            byte_addr_q  <= '0;
            byte_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            byte_out_q   <= byte_out_d;
            byte_addr_q  <= byte_addr_d;
            byte_valid_q <= byte_valid_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            sync_err_q   <= sync_err_d;
        end
    end

    capture_ram #(
        .BYTE_W (BYTE_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_capture_ram (
        .sysclk  (sysclk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (byte_cnt_q),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign bus.byte_out   = byte_out_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.byte_addr  = byte_addr_q;
    assign bus.frame_done = frame_done_q;
    assign busy           = busy_q;
    assign sync_err       = sync_err_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb/tb_serial_frame_receiver.sv - directed self-checking bench for serial_frame_receiver
`timescale 1ns/1ps
module tb_serial_frame_receiver;

    logic       sysclk    = 1'b0;
    logic       rst_n     = 1'b1;
    logic       clear_err = 1'b0;
    logic [3:0] rd_addr   = 4'd0;
    logic [7:0] rd_data;
    logic       busy;
    logic       sync_err;

    serial_frame_receiver_if bus ();

    serial_frame_receiver dut (
        .sysclk    (sysclk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .sync_err  (sync_err),
        .clear_err (clear_err),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always #5 sysclk = ~sysclk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always @(posedge sysclk) cyc <= cyc + 1;

    logic [7:0] mon_data [256];
    logic [3:0] mon_addr [256];
    logic       mon_fd   [256];
    int         mon_cyc  [256];
    int         mon_n = 0;
    int         fd_n  = 0;

    always @(negedge sysclk) begin
        if (bus.byte_valid === 1'b1 && mon_n < 256) begin
            mon_data[mon_n] = bus.byte_out;
            mon_addr[mon_n] = bus.byte_addr;
            mon_fd[mon_n]   = bus.frame_done;
            mon_cyc[mon_n]  = cyc;
            mon_n           = mon_n + 1;
        end
        if (bus.frame_done === 1'b1) fd_n = fd_n + 1;
    end

    logic [7:0] tx [16];
    bit         gap_mode     = 1'b0;
    bit         clr_on_start = 1'b0;
    int         frame_c0     = 0;

    task automatic send_bit(input logic b, input logic fs);
        @(negedge sysclk);
        bus.din         = b;
        bus.din_valid   = 1'b1;
        bus.frame_start = fs;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge sysclk);
            bus.din         = 1'b0;
            bus.din_valid   = 1'b0;
            bus.frame_start = 1'b0;
        end
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits, input logic fs_first);
        for (int k = 0; k < nbits; k++) send_bit(b[7-k], fs_first && (k == 0));
    endtask

    // Whole frame from tx[]; with gap_mode every third driven cycle is a gap.
    task automatic send_frame();
        int t = 0;
        for (int i = 0; i < 128; i++) begin
            while (gap_mode && (t % 3 == 2)) begin
                gap(1);
                t++;
            end
            send_bit(tx[i/8][7-(i%8)], i == 0);
            clear_err = (i == 0) ? clr_on_start : 1'b0;
            if (i == 0) frame_c0 = cyc;
            t++;
        end
    endtask

    task automatic test_reset();
        int base;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge sysclk);
        vectors++;
        if ({bus.byte_valid, bus.frame_done, busy, sync_err, bus.byte_addr, bus.byte_out, rd_data} !== 24'd0) begin
            $display("FAIL reset_outputs got bv=%b fd=%b busy=%b err=%b addr=%0d out=%h rd=%h, want all 0",
                     bus.byte_valid, bus.frame_done, busy, sync_err, bus.byte_addr, bus.byte_out, rd_data);
            miscompares++;
        end
        rst_n = 1'b1;
        rd_addr = 4'd0;
        send_partial(8'hC3, 8, 1'b1);
        send_partial(8'h3C, 8, 1'b0);
        gap(2);
        vectors++;
        if ({busy, bus.byte_out, bus.byte_addr, rd_data} !== {1'b1, 8'h3C, 4'd1, 8'hC3}) begin
            $display("FAIL pre_reset_state got busy=%b out=%h addr=%0d rd=%h, want busy=1 out=3c addr=1 rd=c3",
                     busy, bus.byte_out, bus.byte_addr, rd_data);
            miscompares++;
        end
        send_partial(8'hFF, 3, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, bus.byte_valid, bus.byte_out, bus.byte_addr, rd_data} !== 22'd0) begin
            $display("FAIL async_reset got busy=%b bv=%b out=%h addr=%0d rd=%h, want all 0",
                     busy, bus.byte_valid, bus.byte_out, bus.byte_addr, rd_data);
            miscompares++;
        end
        @(negedge sysclk);
        rst_n = 1'b1;
        base = mon_n;
        for (int k = 0; k < 16; k++) send_bit(k[0] ^ k[2], 1'b0);
        gap(2);
        vectors++;
        if (mon_n - base !== 0 || busy !== 1'b0) begin
            $display("FAIL no_start_no_bytes got pulses=%0d busy=%b, want pulses=0 busy=0", mon_n - base, busy);
            miscompares++;
        end
        vectors++;
        if (rd_data !== 8'hC3) begin
            $display("FAIL buf_survives_reset got rd=%h, want c3", rd_data);
            miscompares++;
        end
    endtask

    task automatic test_nominal();
        int base, fd0, i, exp_cyc;
        for (int k = 0; k < 16; k++) tx[k] = 8'(k * 8'h11);
        gap_mode = 1'b0;
        base = mon_n;
        fd0 = fd_n;
        send_frame();
        gap(2);
        vectors++;
        if (mon_n - base !== 16 || fd_n - fd0 !== 1) begin
            $display("FAIL nominal_counts got pulses=%0d done=%0d, want 16 and 1", mon_n - base, fd_n - fd0);
            miscompares++;
        end
        for (int j = 0; j < 16; j++) begin
            i = 8 * j + 7;
            exp_cyc = frame_c0 + 1 + i;
            vectors++;
            if ({mon_addr[base+j], mon_data[base+j], mon_fd[base+j]} !== {4'(j), tx[j], (j == 15)} ||
                mon_cyc[base+j] !== exp_cyc) begin
                $display("FAIL nominal_byte[%0d] got addr=%0d data=%h fd=%b cyc=%0d, want addr=%0d data=%h fd=%b cyc=%0d",
                         j, mon_addr[base+j], mon_data[base+j], mon_fd[base+j], mon_cyc[base+j],
                         j, tx[j], (j == 15), exp_cyc);
                miscompares++;
            end
        end
        vectors++;
        if (sync_err !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL nominal_flags got err=%b busy=%b, want 0 0", sync_err, busy);
            miscompares++;
        end
    endtask

    task automatic test_gaps();
        int base, i, exp_cyc;
        for (int k = 0; k < 16; k++) tx[k] = 8'(k * 8'h11);
        gap_mode = 1'b1;
        base = mon_n;
        send_frame();
        gap_mode = 1'b0;
        gap(2);
        vectors++;
        if (mon_n - base !== 16) begin
            $display("FAIL gaps_count got pulses=%0d, want 16", mon_n - base);
            miscompares++;
        end
        for (int j = 0; j < 16; j++) begin
            i = 8 * j + 7;
            exp_cyc = frame_c0 + 1 + i + i / 2;
            vectors++;
            if ({mon_addr[base+j], mon_data[base+j], mon_fd[base+j]} !== {4'(j), tx[j], (j == 15)} ||
                mon_cyc[base+j] !== exp_cyc) begin
                $display("FAIL gaps_byte[%0d] got addr=%0d data=%h fd=%b cyc=%0d, want addr=%0d data=%h fd=%b cyc=%0d",
                         j, mon_addr[base+j], mon_data[base+j], mon_fd[base+j], mon_cyc[base+j],
                         j, tx[j], (j == 15), exp_cyc);
                miscompares++;
            end
        end
        for (int a = 0; a < 16; a++) begin
            gap(1);
            rd_addr = 4'(a);
            gap(1);
            vectors++;
            if (rd_data !== tx[a]) begin
                $display("FAIL gaps_buf[%0d] got %h, want %h", a, rd_data, tx[a]);
                miscompares++;
            end
        end
    endtask

    task automatic test_framing_error();
        logic [7:0] fa [16];
        logic [7:0] fb [16];
        int base, fd0;
        for (int k = 0; k < 16; k++) begin
            fa[k] = {4'(k), ~4'(k)};
            fb[k] = 8'hF0 ^ 8'(k * 7);
        end
        base = mon_n;
        fd0 = fd_n;
        for (int k = 0; k < 5; k++) send_partial(fa[k], 8, k == 0);
        send_partial(fa[5], 4, 1'b0);
        tx = fb;
        send_frame();
        gap(2);
        vectors++;
        if (mon_n - base !== 21 || fd_n - fd0 !== 1 || sync_err !== 1'b1) begin
            $display("FAIL ferr_counts got pulses=%0d done=%0d err=%b, want 21 1 1", mon_n - base, fd_n - fd0, sync_err);
            miscompares++;
        end
        for (int j = 0; j < 21; j++) begin
            logic [3:0] ea;
            logic [7:0] ed;
            ea = (j < 5) ? 4'(j) : 4'(j - 5);
            ed = (j < 5) ? fa[j] : fb[j-5];
            vectors++;
            if ({mon_addr[base+j], mon_data[base+j], mon_fd[base+j]} !== {ea, ed, (j == 20)}) begin
                $display("FAIL ferr_byte[%0d] got addr=%0d data=%h fd=%b, want addr=%0d data=%h fd=%b",
                         j, mon_addr[base+j], mon_data[base+j], mon_fd[base+j], ea, ed, (j == 20));
                miscompares++;
            end
        end
        send_partial(fa[0], 3, 1'b1);
        tx = fa;
        clr_on_start = 1'b1;
        send_frame();
        clr_on_start = 1'b0;
        gap(2);
        vectors++;
        if (sync_err !== 1'b1) begin
            $display("FAIL set_beats_clear got err=%b, want 1", sync_err);
            miscompares++;
        end
        clear_err = 1'b1;
        gap(1);
        clear_err = 1'b0;
        vectors++;
        if (sync_err !== 1'b0) begin
            $display("FAIL clear_alone got err=%b, want 0", sync_err);
            miscompares++;
        end
        base = mon_n;
        send_partial(fb[0], 8, 1'b1);
        send_partial(fb[1], 7, 1'b0);
        tx = fa;
        send_frame();
        gap(2);
        vectors++;
        if (mon_n - base !== 17 || sync_err !== 1'b1 ||
            {mon_addr[base], mon_data[base], mon_addr[base+1], mon_data[base+1]} !== {4'd0, fb[0], 4'd0, fa[0]}) begin
            $display("FAIL restart_on_8th_bit got pulses=%0d err=%b a0=%0d d0=%h a1=%0d d1=%h, want 17 1 0 %h 0 %h",
                     mon_n - base, sync_err, mon_addr[base], mon_data[base], mon_addr[base+1], mon_data[base+1],
                     fb[0], fa[0]);
            miscompares++;
        end
        clear_err = 1'b1;
        gap(1);
        clear_err = 1'b0;
    endtask

    task automatic test_readback();
        logic [7:0] f1 [16];
        logic [7:0] f2 [16];
        for (int k = 0; k < 16; k++) begin
            f1[k] = ((k % 2) != 0 ? 8'h5A : 8'hA5) ^ 8'(k);
            f2[k] = ~f1[k];
        end
        tx = f1;
        send_frame();
        for (int a = 0; a < 16; a++) begin
            gap(1);
            rd_addr = 4'(a);
            gap(1);
            vectors++;
            if (rd_data !== f1[a]) begin
                $display("FAIL readback[%0d] got %h, want %h", a, rd_data, f1[a]);
                miscompares++;
            end
        end
        for (int k = 0; k < 16; k++) begin
            send_partial(f2[k], 8, k == 0);
            if (k == 3) begin
                rd_addr = 4'd3;
                gap(1);
                vectors++;
                if (rd_data !== f1[3]) begin
                    $display("FAIL read_before_write got %h, want old %h", rd_data, f1[3]);
                    miscompares++;
                end
                gap(1);
                vectors++;
                if (rd_data !== f2[3]) begin
                    $display("FAIL read_after_write got %h, want new %h", rd_data, f2[3]);
                    miscompares++;
                end
            end
        end
        gap(2);
    endtask

    task automatic test_back_to_back();
        logic [7:0] ta [16];
        logic [7:0] tb2 [16];
        int base, fd0;
        for (int k = 0; k < 16; k++) begin
            ta[k]  = 8'(k * 29 + 3);
            tb2[k] = 8'(255 - k * 13);
        end
        base = mon_n;
        fd0 = fd_n;
        tx = ta;
        send_frame();
        tx = tb2;
        send_frame();
        gap(2);
        vectors++;
        if (mon_n - base !== 32 || fd_n - fd0 !== 2 || sync_err !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL b2b_counts got pulses=%0d done=%0d err=%b busy=%b, want 32 2 0 0",
                     mon_n - base, fd_n - fd0, sync_err, busy);
            miscompares++;
        end
        for (int j = 0; j < 32; j++) begin
            logic [7:0] ed;
            ed = (j < 16) ? ta[j] : tb2[j-16];
            vectors++;
            if ({mon_addr[base+j], mon_data[base+j], mon_fd[base+j]} !== {4'(j % 16), ed, (j % 16 == 15)}) begin
                $display("FAIL b2b_byte[%0d] got addr=%0d data=%h fd=%b, want addr=%0d data=%h fd=%b",
                         j, mon_addr[base+j], mon_data[base+j], mon_fd[base+j], j % 16, ed, (j % 16 == 15));
                miscompares++;
            end
        end
    endtask

    initial begin
        bus.din         = 1'b0;
        bus.din_valid   = 1'b0;
        bus.frame_start = 1'b0;
        test_reset();
        test_nominal();
        test_gaps();
        test_framing_error();
        test_readback();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d, want bench complete", cyc);
        $fatal(1);
    end

endmodule
